multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS-subset datapath: a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It replaces single-cycle opcode decoding so that one ALU and one unified memory port are shared across cycles. It drives every datapath mux, enable and write strobe. It waits on a memory-ready handshake and keeps a retired-instruction counter.

## Interface
- No parameters; encodings are fixed in the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Opcode  in  6  IR[31:26], stable from end of FETCH until return to FETCH
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- Beq / Bne  out  1 each  conditional PC load on ALU zero / not-zero
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead / MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- MemToReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUop  out  2  00 = add, 01 = subtract/compare, 10 = funct field, 11 = jump
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- IllegalOp  out  1  one-cycle pulse on an unknown opcode
- State  out  4  current state, for debug
- InstrRetired  out  1  one-cycle pulse when an instruction completes
- RetiredCount  out  32  retired-instruction counter

## Operation
- Opcodes: R = 0x00, lw = 0x31, sw = 0x35, beq = 0x08, bne = 0x37, j = 0x21. Any other value is illegal.
- States and encoding: RESET 0, FETCH 1, DECODE 2, MEMADDR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, RWB 8, BRANCH 9, JUMP 10. Values 11–15 are unreachable and return to FETCH.
- Outputs depend only on state, except the MemReady-qualified strobes noted below. Any output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (precomputes the branch target). Next state by opcode:
  - lw, sw → MEMADDR
  - R → EXECUTE
  - beq, bne → BRANCH
  - j → JUMP
  - illegal → FETCH, with IllegalOp=1 in this DECODE cycle
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Next state is FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Waits for MemReady, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next state is RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01. Beq=1 for opcode 0x08, Bne=1 for 0x37. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10, ALUop=11. Next state is FETCH.
- InstrRetired=1 in these final cycles:
  - MEMWB, RWB, BRANCH, JUMP
  - MEMWRITE, only when MemReady=1
- RetiredCount increments by 1 on each InstrRetired cycle and wraps from 0xFFFFFFFF to 0. Illegal opcodes do not count.

## Timing
- rst sampled high at any edge: the next state is RESET, RetiredCount is 0, and every output is 0 in the following cycle. An in-flight memory access is abandoned (strobes drop).
- Cycle counts with MemReady constantly 1: R = 4, lw = 5, sw = 4, beq/bne = 3, j = 3, illegal = 2. Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemRead/MemWrite stay high and IorD stays stable for the whole wait.
- Opcode is sampled only in DECODE, MEMADDR and BRANCH.

## Structure
- Package ctrl_pkg holds:
  - opcode constants
  - the state enum (4-bit)
  - ALUop, ALUSrcB and PCSource encodings
- Sub-module opcode_class: combinational; Opcode → one-hot {rtype, lw, sw, beq, bne, j, illegal}. It is used by DECODE, MEMADDR and BRANCH.
- Top level: state register, next-state logic, output decode, retire counter.

## Test plan
- Reset then add (Opcode 0x00), MemReady=1 → State 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in RWB; RetiredCount=1.
- lw (0x31) with MemReady low for 2 cycles in MEMREAD → 7 cycles; MemRead and IorD=1 held throughout MEMREAD; MEMWB has MemToReg=1.
- sw (0x35), then bne (0x37), then j (0x21) → MemWrite pulse with InstrRetired in the same cycle; Bne=1 with PCSource=01; PCWrite=1 with PCSource=10; RetiredCount=3.
- Opcode 0x3F → IllegalOp pulse in DECODE, return to FETCH, RetiredCount unchanged.
- rst asserted while in MEMREAD → next cycle State=0, all outputs 0, RetiredCount=0, then FETCH.
- Preload RetiredCount to 0xFFFFFFFF via 2^32−1 retires (or force) plus one beq (0x08) → wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: opcodes, states,
// datapath mux selects and the decoded opcode class.
package ctrl_pkg;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h31;
    localparam logic [5:0] OP_SW  = 6'h35;
    localparam logic [5:0] OP_BEQ = 6'h08;
    localparam logic [5:0] OP_BNE = 6'h37;
    localparam logic [5:0] OP_J   = 6'h21;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADDR  = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECUTE  = 4'd7,
        ST_RWB      = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_JUMP  = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_e;

    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: one-hot instruction class from IR[31:26].
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OP_R:    op_class.rtype   = 1'b1;
            OP_LW:   op_class.lw      = 1'b1;
            OP_SW:   op_class.sw      = 1'b1;
            OP_BEQ:  op_class.beq     = 1'b1;
            OP_BNE:  op_class.bne     = 1'b1;
            OP_J:    op_class.j       = 1'b1;
            default: op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle datapath: state register, next-state
// logic, per-state control decode and a free-running retired-instruction count.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Opcode,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        Beq,
    output logic        Bne,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUop,
    output logic [1:0]  PCSource,
    output logic        IllegalOp,
    output logic [3:0]  State,
    output logic        InstrRetired,
    output logic [31:0] RetiredCount
);

    state_e      state_q, state_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic        instr_retired;
    op_class_t   op_class;

    opcode_class u_opcode_class (
        .opcode   (Opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RESET;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:    state_d = ST_FETCH;
            ST_FETCH:    state_d = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (op_class.lw || op_class.sw)        state_d = ST_MEMADDR;
                else if (op_class.rtype)               state_d = ST_EXECUTE;
                else if (op_class.beq || op_class.bne) state_d = ST_BRANCH;
                else if (op_class.j)                   state_d = ST_JUMP;
                else                                   state_d = ST_FETCH;
            end
            ST_MEMADDR: begin
                if (op_class.lw)      state_d = ST_MEMREAD;
                else if (op_class.sw) state_d = ST_MEMWRITE;
                else                  state_d = ST_FETCH;
            end
            ST_MEMREAD:  state_d = MemReady ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: state_d = MemReady ? ST_FETCH : ST_MEMWRITE;
            ST_EXECUTE:  state_d = ST_RWB;
            ST_RWB:      state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Only the FETCH/MEMWRITE strobes and the opcode-qualified DECODE/BRANCH
    // flags look past the state register.
    always_comb begin
        PCWrite       = 1'b0;
        Beq           = 1'b0;
        Bne           = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemToReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_RT;
        ALUop         = ALU_ADD;
        PCSource      = PCSRC_ALU;
        IllegalOp     = 1'b0;
        instr_retired = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            ST_DECODE: begin
                ALUSrcB   = SRCB_IMM_SH2;
                IllegalOp = op_class.illegal;
            end
            ST_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite      = 1'b1;
                MemToReg      = 1'b1;
                instr_retired = 1'b1;
            end
            ST_MEMWRITE: begin
                MemWrite      = 1'b1;
                IorD          = 1'b1;
                instr_retired = MemReady;
            end
            ST_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUop   = ALU_FUNCT;
            end
            ST_RWB: begin
                RegWrite      = 1'b1;
                RegDst        = 1'b1;
                instr_retired = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUop         = ALU_SUB;
                PCSource      = PCSRC_ALUOUT;
                Beq           = op_class.beq;
                Bne           = op_class.bne;
                instr_retired = 1'b1;
            end
            ST_JUMP: begin
                PCWrite       = 1'b1;
                PCSource      = PCSRC_JUMP;
                ALUop         = ALU_JUMP;
                instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        retired_count_d = retired_count_q + 32'(instr_retired);
    end

    assign InstrRetired = instr_retired;
    assign RetiredCount = retired_count_q;
    assign State        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table followed by
// a hand-written retire-counter wrap sequence.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Opcode;
    logic        MemReady;
    logic        PCWrite, Beq, Bne, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA, IllegalOp, InstrRetired;
    logic [1:0]  ALUSrcB, ALUop, PCSource;
    logic [3:0]  State;
    logic [31:0] RetiredCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk          (clk),
        .rst          (rst),
        .Opcode       (Opcode),
        .MemReady     (MemReady),
        .PCWrite      (PCWrite),
        .Beq          (Beq),
        .Bne          (Bne),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .MemToReg     (MemToReg),
        .RegDst       (RegDst),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUop        (ALUop),
        .PCSource     (PCSource),
        .IllegalOp    (IllegalOp),
        .State        (State),
        .InstrRetired (InstrRetired),
        .RetiredCount (RetiredCount)
    );

    // Field order: PCWrite Beq Bne IorD MemRead MemWrite IRWrite MemToReg
    //              RegDst RegWrite ALUSrcA ALUSrcB ALUop PCSource IllegalOp InstrRetired
    logic [18:0] act_ctl;
    assign act_ctl = {PCWrite, Beq, Bne, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, IllegalOp,
                      InstrRetired};

    localparam logic [18:0] E_RESET    = '0;
    localparam logic [18:0] E_FETCH    = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [18:0] E_FETCH_W  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [18:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
    localparam logic [18:0] E_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b0};
    localparam logic [18:0] E_MEMADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    localparam logic [18:0] E_MEMREAD  = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [18:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1};
    localparam logic [18:0] E_MEMWR_W  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [18:0] E_MEMWR_R  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1};
    localparam logic [18:0] E_EXECUTE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [18:0] E_RWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1};
    localparam logic [18:0] E_BEQ      = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b1};
    localparam logic [18:0] E_BNE      = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b1};
    localparam logic [18:0] E_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b10,1'b0,1'b1};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [5:0] o, input logic m,
                       input logic [3:0] s, input logic [18:0] c, input logic [31:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = m; v.st = s; v.ctl = c; v.cnt = n;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        // add: RESET FETCH DECODE EXECUTE RWB
        add(0, 6'h00, 1, 4'd0,  E_RESET,   0);
        add(0, 6'h00, 1, 4'd1,  E_FETCH,   0);
        add(0, 6'h00, 1, 4'd2,  E_DECODE,  0);
        add(0, 6'h00, 1, 4'd7,  E_EXECUTE, 0);
        add(0, 6'h00, 1, 4'd8,  E_RWB,     0);
        // lw with two wait cycles in MEMREAD
        add(0, 6'h31, 1, 4'd1,  E_FETCH,   1);
        add(0, 6'h31, 1, 4'd2,  E_DECODE,  1);
        add(0, 6'h31, 1, 4'd3,  E_MEMADDR, 1);
        add(0, 6'h31, 0, 4'd4,  E_MEMREAD, 1);
        add(0, 6'h31, 0, 4'd4,  E_MEMREAD, 1);
        add(0, 6'h31, 1, 4'd4,  E_MEMREAD, 1);
        add(0, 6'h31, 1, 4'd5,  E_MEMWB,   1);
        // sw with one wait in FETCH and one in MEMWRITE
        add(0, 6'h35, 0, 4'd1,  E_FETCH_W, 2);
        add(0, 6'h35, 1, 4'd1,  E_FETCH,   2);
        add(0, 6'h35, 1, 4'd2,  E_DECODE,  2);
        add(0, 6'h35, 1, 4'd3,  E_MEMADDR, 2);
        add(0, 6'h35, 0, 4'd6,  E_MEMWR_W, 2);
        add(0, 6'h35, 1, 4'd6,  E_MEMWR_R, 2);
        // bne, j
        add(0, 6'h37, 1, 4'd1,  E_FETCH,   3);
        add(0, 6'h37, 1, 4'd2,  E_DECODE,  3);
        add(0, 6'h37, 1, 4'd9,  E_BNE,     3);
        add(0, 6'h21, 1, 4'd1,  E_FETCH,   4);
        add(0, 6'h21, 1, 4'd2,  E_DECODE,  4);
        add(0, 6'h21, 1, 4'd10, E_JUMP,    4);
        // illegal opcode: two cycles, no retire
        add(0, 6'h3F, 1, 4'd1,  E_FETCH,   5);
        add(0, 6'h3F, 1, 4'd2,  E_DEC_ILL, 5);
        // lw abandoned by reset in MEMREAD
        add(0, 6'h31, 1, 4'd1,  E_FETCH,   5);
        add(0, 6'h31, 1, 4'd2,  E_DECODE,  5);
        add(0, 6'h31, 1, 4'd3,  E_MEMADDR, 5);
        add(0, 6'h31, 0, 4'd4,  E_MEMREAD, 5);
        add(1, 6'h31, 0, 4'd4,  E_MEMREAD, 5);
        add(0, 6'h31, 0, 4'd0,  E_RESET,   0);
        add(0, 6'h08, 1, 4'd1,  E_FETCH,   0);

        rst = 1'b1; Opcode = 6'h00; MemReady = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; Opcode = vq[i].op; MemReady = vq[i].rdy;
            #1;
            $display("vec %0d: rst=%0d op=%h rdy=%0d state=%0d ctl=%h cnt=%0d",
                     i, rst, Opcode, MemReady, State, act_ctl, RetiredCount);
            chk($sformatf("v%0d_state", i), 32'(State), 32'(vq[i].st));
            chk($sformatf("v%0d_ctl", i), 32'(act_ctl), 32'(vq[i].ctl));
            chk($sformatf("v%0d_cnt", i), RetiredCount, vq[i].cnt);
        end

        // beq at the counter's top value: held at all-ones across the DECODE edge
        @(negedge clk);
        chk("wrap_decode_state", 32'(State), 32'd2);
        force dut.retired_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_count_q;
        #1;
        $display("wrap: state=%0d ctl=%h cnt=%h", State, act_ctl, RetiredCount);
        chk("wrap_branch_state", 32'(State), 32'd9);
        chk("wrap_branch_ctl", 32'(act_ctl), 32'(E_BEQ));
        chk("wrap_preload_cnt", RetiredCount, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        $display("wrap: state=%0d cnt=%h", State, RetiredCount);
        chk("wrap_fetch_state", 32'(State), 32'd1);
        chk("wrap_cnt_zero", RetiredCount, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
